// File: rtl/draw_sequencer.sv
// Frame-draw scheduler: runs an erase pass, a position-update pulse, then a draw
// pass over all enabled sprite channels through one shared drawer; freezes on collision.
module draw_sequencer #(
  parameter int NUM_CH = 4,
  parameter int ID_W   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_tick,
  input  logic [NUM_CH-1:0] ch_enable,
  input  logic              done,
  input  logic              collision,
  input  logic              restart,
  output logic              start,
  output logic              phase,
  output logic [ID_W-1:0]   grant_id,
  output logic              update,
  output logic              clear_start,
  output logic              frame_done,
  output logic              busy,
  output logic              frozen,
  output logic              overrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_UPDATE,
    S_FROZEN,
    S_CLR_ISSUE,
    S_CLR_WAIT
  } state_t;

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_CH - 1);

  state_t            state_q, state_d;
  logic [ID_W-1:0]   idx_q, idx_d;
  logic              phase_q, phase_d;
  logic [NUM_CH-1:0] en_snap_q, en_snap_d;
  logic              coll_lat_q, coll_lat_d;
  logic              overrun_q, overrun_d;
  logic              frame_done_q, frame_done_d;
  logic              ch_en;
  logic              is_last;
  logic              end_pass;
  logic              clr_done;

  // Explicit compare keeps the channel select safe when 2^ID_W > NUM_CH.
  always_comb begin
    ch_en = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (idx_q == ID_W'(i)) ch_en = en_snap_q[i];
    end
  end

  assign is_last  = (idx_q == LAST_ID);
  assign clr_done = (state_q == S_CLR_WAIT) && done;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    phase_d      = phase_q;
    en_snap_d    = en_snap_q;
    frame_done_d = 1'b0;
    end_pass     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (coll_lat_q) begin
          state_d = S_FROZEN;
        end else if (frame_tick) begin
          en_snap_d = ch_enable;
          phase_d   = 1'b0;
          idx_d     = '0;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (ch_en)         state_d  = S_WAIT;
        else if (!is_last) idx_d    = idx_q + ID_W'(1);
        else               end_pass = 1'b1;
      end
      S_WAIT: begin
        if (done) begin
          if (!is_last) begin
            idx_d   = idx_q + ID_W'(1);
            state_d = S_ISSUE;
          end else begin
            end_pass = 1'b1;
          end
        end
      end
      S_UPDATE: begin
        phase_d = 1'b1;
        idx_d   = '0;
        state_d = S_ISSUE;
      end
      S_FROZEN: begin
        if (restart) state_d = S_CLR_ISSUE;
      end
      S_CLR_ISSUE: state_d = S_CLR_WAIT;
      S_CLR_WAIT: begin
        if (done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A collision arriving with the final done still freezes straight after this frame.
    if (end_pass) begin
      if (!phase_q) begin
        state_d = S_UPDATE;
      end else begin
        frame_done_d = 1'b1;
        state_d      = (coll_lat_q || collision) ? S_FROZEN : S_IDLE;
      end
    end
  end

  always_comb begin
    coll_lat_d = collision | (coll_lat_q & ~clr_done);
    overrun_d  = clr_done ? 1'b0 : (overrun_q | (frame_tick & busy));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      phase_q      <= 1'b0;
      en_snap_q    <= '0;
      coll_lat_q   <= 1'b0;
      overrun_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      phase_q      <= phase_d;
      en_snap_q    <= en_snap_d;
      coll_lat_q   <= coll_lat_d;
      overrun_q    <= overrun_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign start       = (state_q == S_ISSUE) && ch_en;
  assign phase       = phase_q;
  assign grant_id    = idx_q;
  assign update      = (state_q == S_UPDATE);
  assign clear_start = (state_q == S_CLR_ISSUE);
  assign frame_done  = frame_done_q;
  assign busy        = !((state_q == S_IDLE) || (state_q == S_FROZEN));
  assign frozen      = (state_q == S_FROZEN) || (state_q == S_CLR_ISSUE) ||
                       (state_q == S_CLR_WAIT);
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_draw_sequencer.sv
// Bench for draw_sequencer: table of frames checked through a start scoreboard,
// plus hand sequences for collision/freeze, restart, overrun and mid-frame reset.
module tb_draw_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic [3:0] ch_enable;
  logic       done_auto, done_man, done_in;
  logic       collision;
  logic       restart;
  logic       start, phase, update, clear_start, frame_done, busy, frozen, overrun;
  logic [1:0] grant_id;
  logic [9:0] outs;

  assign done_in = done_auto | done_man;
  assign outs = {start, phase, grant_id, update, clear_start, frame_done, busy, frozen, overrun};

  draw_sequencer #(.NUM_CH(4), .ID_W(2)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .ch_enable(ch_enable),
    .done(done_in), .collision(collision), .restart(restart),
    .start(start), .phase(phase), .grant_id(grant_id), .update(update),
    .clear_start(clear_start), .frame_done(frame_done), .busy(busy),
    .frozen(frozen), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] en;
    int         dly;
    int         fd;
    int         upd;
    int         nst;
  } vec_t;

  vec_t       tbl [6];
  int         coll_tbl [3];
  logic [2:0] exp_q [$];
  int n_cmp = 0, n_fail = 0;
  int cyc, fd_cyc, upd_cyc, n_upd, n_starts, busy_cnt, dcnt, drv_dly;
  logic auto_drv;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: sample outputs on the falling edge, score starts, model the drawer.
  task automatic step();
    logic [2:0] e;
    @(negedge clk);
    cyc++;
    if (start) begin
      n_starts++;
      check("start_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("start_phase_id", {29'd0, phase, grant_id}, {29'd0, e});
      end
    end
    if (update) begin
      upd_cyc = cyc;
      n_upd++;
    end
    if (frame_done && fd_cyc < 0) fd_cyc = cyc;
    done_auto = 1'b0;
    if (dcnt > 0) begin
      dcnt--;
      if (dcnt == 0) done_auto = 1'b1;
    end
    if (start && auto_drv) dcnt = drv_dly;
  endtask

  task automatic run_frame(input string tag, input logic [3:0] en, input int dly,
                           input int tick_at, input int coll_at,
                           input int exp_fd, input int exp_upd, input int exp_nst);
    step();
    for (int ph = 0; ph < 2; ph++)
      for (int i = 0; i < 4; i++)
        if (en[i]) exp_q.push_back({ph[0], i[1:0]});
    auto_drv   = 1'b1;
    drv_dly    = dly;
    ch_enable  = en;
    frame_tick = 1'b1;
    collision  = (coll_at == 0);
    cyc = 0; fd_cyc = -1; upd_cyc = -1; n_upd = 0; n_starts = 0; busy_cnt = 0;
    while (fd_cyc < 0 && cyc < 300) begin
      step();
      if (busy) busy_cnt++;
      frame_tick = (cyc == tick_at);
      collision  = (cyc == coll_at);
      if (cyc == 3) ch_enable = ~en;
    end
    frame_tick = 1'b0;
    collision  = 1'b0;
    check({tag, "_frame_done_cycle"}, fd_cyc, exp_fd);
    check({tag, "_update_cycle"}, upd_cyc, exp_upd);
    check({tag, "_update_count"}, n_upd, 1);
    check({tag, "_start_count"}, n_starts, exp_nst);
    check({tag, "_busy_cycles"}, busy_cnt, exp_fd - 1);
    check({tag, "_scoreboard_left"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic do_restart(input string tag);
    restart = 1'b1;
    step();
    restart = 1'b0;
    check({tag, "_clear_start"}, clear_start, 1);
    check({tag, "_frozen_in_clr"}, frozen, 1);
    step();
    check({tag, "_clear_start_one_cycle"}, clear_start, 0);
    done_man = 1'b1;
    step();
    done_man = 1'b0;
    check({tag, "_frozen_after_clear"}, frozen, 0);
    check({tag, "_busy_after_clear"}, busy, 0);
  endtask

  initial begin
    // cycles: erase pass P = sum(enabled ? 1+dly : 1), update at P+1, frame_done at 2P+2
    tbl[0] = '{4'b1111, 1, 18,  9, 8};
    tbl[1] = '{4'b0101, 1, 14,  7, 4};
    tbl[2] = '{4'b0000, 1, 10,  5, 0};
    tbl[3] = '{4'b1000, 3, 16,  8, 2};
    tbl[4] = '{4'b1111, 2, 26, 13, 8};
    tbl[5] = '{4'b0110, 1, 14,  7, 4};
    coll_tbl = '{2, 0, 17};

    reset = 1'b1; frame_tick = 1'b0; ch_enable = 4'b0; done_auto = 1'b0; done_man = 1'b0;
    collision = 1'b0; restart = 1'b0; auto_drv = 1'b1; drv_dly = 1; dcnt = 0;
    cyc = 0; fd_cyc = -1; upd_cyc = -1; n_upd = 0; n_starts = 0; busy_cnt = 0;
    #1;
    check("reset_outputs", {22'd0, outs}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int t = 0; t < 6; t++)
      run_frame($sformatf("tbl%0d", t), tbl[t].en, tbl[t].dly, -1, -1,
                tbl[t].fd, tbl[t].upd, tbl[t].nst);

    for (int c = 0; c < 3; c++) begin
      run_frame($sformatf("coll%0d", c), 4'b1111, 1, -1, coll_tbl[c], 18, 9, 8);
      check("coll_frozen_at_frame_done", frozen, 1);
      n_starts = 0; busy_cnt = 0;
      for (int k = 0; k < 8; k++) begin
        frame_tick = !k[0];
        done_man   = (k == 5);
        step();
        if (busy) busy_cnt++;
      end
      frame_tick = 1'b0; done_man = 1'b0;
      check("frozen_no_start", n_starts, 0);
      check("frozen_not_busy", busy_cnt, 0);
      check("frozen_no_overrun", overrun, 0);
      check("frozen_holds", frozen, 1);
      do_restart($sformatf("restart%0d", c));
    end

    check("overrun_clear_before", overrun, 0);
    run_frame("overrun", 4'b1111, 3, 3, -1, 34, 17, 8);
    check("overrun_set", overrun, 1);
    n_starts = 0; busy_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (busy) busy_cnt++;
    end
    check("overrun_no_second_frame", n_starts, 0);
    check("overrun_idle_not_busy", busy_cnt, 0);
    run_frame("after_overrun", 4'b0101, 1, -1, -1, 14, 7, 4);
    check("overrun_sticky", overrun, 1);

    step();
    exp_q.push_back(3'b000);
    ch_enable  = 4'b1111;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    check("rst_mid_start_seen", start, 1);
    reset = 1'b1;
    #1;
    check("rst_mid_outputs_zero", {22'd0, outs}, 0);
    exp_q.delete(); dcnt = 0; done_auto = 1'b0;
    step();
    reset = 1'b0;
    n_starts = 0; busy_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      done_man = k[0];
      step();
      if (busy) busy_cnt++;
    end
    done_man = 1'b0;
    check("rst_done_ignored_starts", n_starts, 0);
    check("rst_done_ignored_busy", busy_cnt, 0);
    check("rst_overrun_cleared", overrun, 0);
    run_frame("after_reset", 4'b1111, 1, -1, -1, 18, 9, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
